// File: rtl/fsm_id_matcher.sv
// ---------------------------------------------------------------------------
// fsm_id_matcher
// Serial identifier recogniser. After 'start' is seen the block shifts ID_W
// bits in from 'in' (MSB first) and compares the finished word against a
// table of NUM_ID identifiers. A match reports 'hit' plus the lowest
// matching table index. Dropping 'start' mid-frame aborts the frame with an
// 'err' pulse. With CONT=1, frames run back-to-back while 'start' stays high.
//
// Ports
//   clk    in   1      system clock, rising edge
//   rst    in   1      asynchronous reset, active-low
//   start  in   1      frame enable, level-sensitive
//   in     in   1      serial data, MSB first
//   hit    out  1      1-cycle pulse: completed frame matched a table entry
//   out    out  ID_W   last completed frame word, held until the next one
//   idx    out  IDX_W  lowest matching table index, held after a hit
//   done   out  1      1-cycle pulse at every frame completion
//   err    out  1      1-cycle pulse: frame aborted by start dropping
// ---------------------------------------------------------------------------
module fsm_id_matcher #(
  parameter int                     ID_W    = 4,
  parameter int                     NUM_ID  = 4,
  parameter logic [NUM_ID*ID_W-1:0] ID_LIST = {4'd8, 4'd4, 4'd2, 4'd1},
  parameter bit                     CONT    = 1'b0,
  localparam int                    IDX_W   = (NUM_ID > 1) ? $clog2(NUM_ID) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in,
  output logic             hit,
  output logic [ID_W-1:0]  out,
  output logic [IDX_W-1:0] idx,
  output logic             done,
  output logic             err
);

  localparam int CNT_W = $clog2(ID_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ID_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK, WAIT} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ID_W-1:0]    shreg_q;
  logic [ID_W-1:0]    out_q;
  logic [IDX_W-1:0]   idx_q;
  logic               hit_q;
  logic               done_q;
  logic               err_q;

  logic               match_d;
  logic [IDX_W-1:0]   match_idx_d;

  // Scan from the top entry down so the lowest matching index is the one
  // left standing when duplicates exist in the table.
  always_comb begin
    match_d     = 1'b0;
    match_idx_d = '0;
    for (int i = NUM_ID - 1; i >= 0; i--) begin
      if (ID_LIST[i*ID_W +: ID_W] == shreg_q) begin
        match_d     = 1'b1;
        match_idx_d = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      out_q   <= '0;
      idx_q   <= '0;
      hit_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // Status outputs are single-cycle pulses unless re-armed below.
      hit_q  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SHIFT;
            cnt_q   <= '0;
          end
        end
        SHIFT: begin
          if (!start) begin
            // Abort: the bit on this edge is discarded, out/idx untouched.
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b1;
          end else begin
            shreg_q <= {shreg_q[ID_W-2:0], in};
            if (cnt_q == LAST_CNT) begin
              state_q <= CHECK;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        CHECK: begin
          // The frame completes here regardless of start.
          out_q  <= shreg_q;
          done_q <= 1'b1;
          if (match_d) begin
            hit_q <= 1'b1;
            idx_q <= match_idx_d;
          end
          if (start && CONT) begin
            state_q <= SHIFT;
            cnt_q   <= '0;
          end else if (start) begin
            state_q <= WAIT;
          end else begin
            state_q <= IDLE;
          end
        end
        WAIT: begin
          // One frame per start assertion in single-frame mode.
          if (!start) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign hit  = hit_q;
  assign out  = out_q;
  assign idx  = idx_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_fsm_id_matcher.sv
// ---------------------------------------------------------------------------
// tb_fsm_id_matcher
// Directed bench for fsm_id_matcher. Two instances share clock and reset:
// u_dut0 runs single-frame mode (CONT=0), u_dut1 continuous mode (CONT=1).
// Expected frame results are queued when the last bit of a frame (or the
// aborting edge) is driven and popped when the DUT raises done or err.
// ---------------------------------------------------------------------------
module tb_fsm_id_matcher;

  logic       clk;
  logic       rst;
  logic       s0, in0, s1, in1;
  logic       hit0, done0, err0, hit1, done1, err1;
  logic [3:0] out0, out1;
  logic [1:0] idx0, idx1;

  int tests_run;
  int tests_failed;

  typedef struct packed {
    logic       is_err;
    logic       hit;
    logic [1:0] idx;
    logic [3:0] out;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  fsm_id_matcher #(
    .ID_W(4), .NUM_ID(4), .ID_LIST({4'd8, 4'd4, 4'd2, 4'd1}), .CONT(1'b0)
  ) u_dut0 (
    .clk(clk), .rst(rst), .start(s0), .in(in0),
    .hit(hit0), .out(out0), .idx(idx0), .done(done0), .err(err0)
  );

  fsm_id_matcher #(
    .ID_W(4), .NUM_ID(4), .ID_LIST({4'd8, 4'd4, 4'd2, 4'd1}), .CONT(1'b1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .start(s1), .in(in1),
    .hit(hit1), .out(out1), .idx(idx1), .done(done1), .err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send0(input logic [3:0] bits);
    for (int i = 3; i >= 0; i--) begin
      in0 = bits[i];
      tick();
    end
  endtask

  task automatic send1(input logic [3:0] bits);
    for (int i = 3; i >= 0; i--) begin
      in1 = bits[i];
      tick();
    end
  endtask

  function automatic exp_t mk(input logic is_err, input logic h,
                              input logic [1:0] i, input logic [3:0] o);
    exp_t e;
    e.is_err = is_err;
    e.hit    = h;
    e.idx    = i;
    e.out    = o;
    return e;
  endfunction

  // Scoreboard side: every done/err pulse must match the oldest queued entry.
  always @(negedge clk) begin
    exp_t e;
    if (done0 || err0) begin
      if (q0.size() == 0) begin
        chk("d0_spurious_event", {29'd0, done0, err0, hit0}, 32'd0);
      end else begin
        e = q0.pop_front();
        chk("d0_kind", {29'd0, err0, done0, hit0}, {29'd0, e.is_err, !e.is_err, e.hit});
        chk("d0_out", {28'd0, out0}, {28'd0, e.out});
        chk("d0_idx", {30'd0, idx0}, {30'd0, e.idx});
      end
    end
    if (done1 || err1) begin
      if (q1.size() == 0) begin
        chk("d1_spurious_event", {29'd0, done1, err1, hit1}, 32'd0);
      end else begin
        e = q1.pop_front();
        chk("d1_kind", {29'd0, err1, done1, hit1}, {29'd0, e.is_err, !e.is_err, e.hit});
        chk("d1_out", {28'd0, out1}, {28'd0, e.out});
        chk("d1_idx", {30'd0, idx1}, {30'd0, e.idx});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b0;
    s0  = 1'b1;
    s1  = 1'b1;
    in0 = 1'b1;
    in1 = 1'b1;

    // T1: reset held with start high and data toggling
    for (int c = 0; c < 4; c++) begin
      tick();
      in0 = ~in0;
      in1 = ~in1;
      chk("t1_dut0_outs", {23'd0, hit0, done0, err0, out0, idx0}, 32'd0);
      chk("t1_dut1_outs", {23'd0, hit1, done1, err1, out1, idx1}, 32'd0);
    end
    s0  = 1'b0;
    s1  = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    chk("t1_idle_after_release", {29'd0, done0, err0, done1}, 32'd0);

    // T2: match 0010 -> idx 1, then WAIT while start stays high
    s0 = 1'b1;
    tick();
    q0.push_back(mk(1'b0, 1'b1, 2'd1, 4'd2));
    send0(4'b0010);
    tick();
    chk("t2_done_latency", {31'd0, done0}, 32'd1);
    chk("t2_hit_latency", {31'd0, hit0}, 32'd1);
    for (int c = 0; c < 8; c++) begin
      in0 = c[0];
      tick();
    end
    chk("t2_wait_no_frame", {30'd0, done0, err0}, 32'd0);
    s0 = 1'b0;
    tick();

    // T3: miss 1111 -> done only, idx keeps 1
    s0 = 1'b1;
    tick();
    q0.push_back(mk(1'b0, 1'b0, 2'd1, 4'hF));
    send0(4'b1111);
    tick();
    chk("t3_done", {31'd0, done0}, 32'd1);
    chk("t3_no_hit", {31'd0, hit0}, 32'd0);
    s0 = 1'b0;
    tick();
    tick();

    // T5: abort after 2 bits, then a frame with start dropped during CHECK
    s0 = 1'b1;
    tick();
    in0 = 1'b0;
    tick();
    in0 = 1'b1;
    tick();
    s0 = 1'b0;
    q0.push_back(mk(1'b1, 1'b0, 2'd1, 4'hF));
    tick();
    chk("t5_err_pulse", {31'd0, err0}, 32'd1);
    chk("t5_no_done_on_abort", {31'd0, done0}, 32'd0);
    tick();
    chk("t5_err_one_cycle", {31'd0, err0}, 32'd0);
    s0 = 1'b1;
    tick();
    q0.push_back(mk(1'b0, 1'b1, 2'd2, 4'd4));
    send0(4'b0100);
    s0 = 1'b0;
    tick();
    chk("t5_hit_after_abort", {30'd0, hit0, err0}, 32'd2);
    tick();
    tick();
    chk("t5_idle_no_event", {30'd0, done0, err0}, 32'd0);

    // T4: continuous mode, three back-to-back frames
    s1 = 1'b1;
    tick();
    q1.push_back(mk(1'b0, 1'b1, 2'd0, 4'd1));
    send1(4'b0001);
    tick();
    chk("t4_f1_done", {30'd0, done1, hit1}, 32'd3);
    q1.push_back(mk(1'b0, 1'b1, 2'd3, 4'd8));
    send1(4'b1000);
    tick();
    chk("t4_f2_done", {30'd0, done1, hit1}, 32'd3);
    q1.push_back(mk(1'b0, 1'b0, 2'd3, 4'd3));
    send1(4'b0011);
    s1 = 1'b0;
    tick();
    chk("t4_f3_done_only", {30'd0, done1, hit1}, 32'd2);
    tick();
    tick();
    chk("t4_stop_no_err", {30'd0, done1, err1}, 32'd0);

    // T6: async reset pulsed mid-SHIFT on both instances
    s0 = 1'b1;
    s1 = 1'b1;
    tick();
    in0 = 1'b1;
    in1 = 1'b1;
    tick();
    in0 = 1'b0;
    in1 = 1'b0;
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("t6_dut0_cleared", {25'd0, hit0, done0, err0, out0, idx0}, 32'd0);
    chk("t6_dut1_cleared", {25'd0, hit1, done1, err1, out1, idx1}, 32'd0);
    #1;
    rst = 1'b1;
    tick();
    q0.push_back(mk(1'b0, 1'b1, 2'd3, 4'd8));
    q1.push_back(mk(1'b0, 1'b1, 2'd2, 4'd4));
    for (int i = 3; i >= 0; i--) begin
      in0 = i[1:0] == 2'd3;
      in1 = i[1:0] == 2'd2;
      tick();
    end
    s0 = 1'b0;
    s1 = 1'b0;
    tick();
    chk("t6_dut0_frame_after_reset", {30'd0, done0, hit0}, 32'd3);
    chk("t6_dut1_frame_after_reset", {30'd0, done1, hit1}, 32'd3);
    tick();
    tick();
    tick();

    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
